// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states, flag bundle.
// Imported by seq_alu and muldiv_iter.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_MOD = 3'b100,
    OP_AND = 3'b101,
    OP_OR  = 3'b110,
    OP_XOR = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIN
  } state_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  function automatic logic isIter(op_t o);
    return (o == OP_MUL) || (o == OP_DIV) ||
           (o == OP_MOD);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider sharing one register pair.
// Ports: clk, rst, load, mode(0=mul,1=div), a, b -> prod_lo/hi, quot, rem, last.
import alu_pkg::*;

module muldiv_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);

  // accReg: product high half / partial remainder
  // shReg : multiplier then product low half / dividend then quotient
  logic [WIDTH-1:0] accReg;
  logic [WIDTH-1:0] shReg;
  logic [WIDTH-1:0] opndReg;
  logic             modeReg;
  logic             run;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divShift;
  logic [WIDTH:0]   divTrial;
  logic             divFits;
  logic [WIDTH-1:0] nextAcc;
  logic [WIDTH-1:0] nextSh;

  always_comb begin
    mulSum   = {1'b0, accReg} +
               (shReg[0] ? {1'b0, opndReg}
                         : {(WIDTH+1){1'b0}});
    divShift = {accReg, shReg[WIDTH-1]};
    divTrial = divShift - {1'b0, opndReg};
    divFits  = divShift >= {1'b0, opndReg};
    nextAcc  = accReg;
    nextSh   = shReg;
    if (modeReg) begin
      // restoring step: keep the subtraction only if it fits
      nextAcc = divFits ? divTrial[WIDTH-1:0]
                        : divShift[WIDTH-1:0];
      nextSh  = {shReg[WIDTH-2:0], divFits};
    end else begin
      // shift the {sum, multiplier} pair right by one
      nextAcc = mulSum[WIDTH:1];
      nextSh  = {mulSum[0], shReg[WIDTH-1:1]};
    end
  end

  assign last = run && (cnt == CW'(WIDTH-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accReg  <= '0;
      shReg   <= '0;
      opndReg <= '0;
      modeReg <= 1'b0;
      run     <= 1'b0;
      cnt     <= '0;
    end else if (load) begin
      accReg  <= '0;
      shReg   <= a;
      opndReg <= b;
      modeReg <= mode;
      run     <= 1'b1;
      cnt     <= '0;
    end else if (run) begin
      accReg <= nextAcc;
      shReg  <= nextSh;
      cnt    <= cnt + 1'b1;
      if (last) run <= 1'b0;
    end
  end

  assign prod_lo = shReg;
  assign prod_hi = accReg;
  assign quot    = shReg;
  assign rem     = accReg;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with start/busy/done handshake and registered NZCV + div-by-zero.
// Ports: clk, rst, start, op, a, b, ci -> busy, done, out, negativo, cero, acarreo, desbordamiento, div_cero.
import alu_pkg::*;

module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             negativo,
  output logic             cero,
  output logic             acarreo,
  output logic             desbordamiento,
  output logic             div_cero
);

  state_t state;
  state_t nextState;

  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic             ciReg;
  op_t              opReg;

  op_t  opIn;
  logic accept;
  logic useIter;
  logic loadMd;
  logic mdMode;

  logic [WIDTH-1:0] prodLo;
  logic [WIDTH-1:0] prodHi;
  logic [WIDTH-1:0] quotV;
  logic [WIDTH-1:0] remV;
  logic             mdLast;

  logic [WIDTH:0]   addFull;
  logic [WIDTH:0]   subFull;
  logic [WIDTH-1:0] resVal;
  logic             cFlag;
  logic             vFlag;
  logic             opDz;
  flags_t           flg;

  assign busy = (state != S_IDLE);

  always_comb begin
    opIn    = op_t'(op);
    accept  = start && (state == S_IDLE);
    // DIV/MOD by zero skips the iterative datapath
    useIter = isIter(opIn) &&
              !((opIn != OP_MUL) && (b == '0));
    loadMd  = accept && useIter;
    mdMode  = (opIn != OP_MUL);
  end

  always_comb begin
    nextState = state;
    unique case (state)
      S_IDLE:
        if (accept)
          nextState = useIter ? S_CALC : S_FIN;
      S_CALC:
        if (mdLast) nextState = S_FIN;
      S_FIN:
        nextState = S_IDLE;
      default:
        nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nextState;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aReg  <= '0;
      bReg  <= '0;
      ciReg <= 1'b0;
      opReg <= OP_ADD;
    end else if (accept) begin
      aReg  <= a;
      bReg  <= b;
      ciReg <= ci;
      opReg <= opIn;
    end
  end

  muldiv_iter #(
    .WIDTH(WIDTH)
  ) uMd (
    .clk    (clk),
    .rst    (rst),
    .load   (loadMd),
    .mode   (mdMode),
    .a      (a),
    .b      (b),
    .prod_lo(prodLo),
    .prod_hi(prodHi),
    .quot   (quotV),
    .rem    (remV),
    .last   (mdLast)
  );

  always_comb begin
    addFull = {1'b0, aReg} + {1'b0, bReg} +
              {{WIDTH{1'b0}}, ciReg};
    subFull = {1'b0, aReg} - {1'b0, bReg};
    opDz    = ((opReg == OP_DIV) ||
               (opReg == OP_MOD)) && (bReg == '0);
    resVal  = '0;
    cFlag   = 1'b0;
    vFlag   = 1'b0;
    unique case (opReg)
      OP_ADD: begin
        resVal = addFull[WIDTH-1:0];
        cFlag  = addFull[WIDTH];
        vFlag  = (aReg[WIDTH-1] == bReg[WIDTH-1]) &&
                 (resVal[WIDTH-1] != aReg[WIDTH-1]);
      end
      OP_SUB: begin
        resVal = subFull[WIDTH-1:0];
        cFlag  = ~subFull[WIDTH];
        vFlag  = (aReg[WIDTH-1] != bReg[WIDTH-1]) &&
                 (resVal[WIDTH-1] != aReg[WIDTH-1]);
      end
      OP_MUL: begin
        resVal = prodLo;
        vFlag  = |prodHi;
      end
      OP_DIV: resVal = opDz ? '1 : quotV;
      OP_MOD: resVal = opDz ? aReg : remV;
      OP_AND: resVal = aReg & bReg;
      OP_OR:  resVal = aReg | bReg;
      OP_XOR: resVal = aReg ^ bReg;
      default: resVal = '0;
    endcase
    flg.n = resVal[WIDTH-1];
    flg.z = (resVal == '0);
    flg.c = cFlag;
    flg.v = vFlag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done           <= 1'b0;
      out            <= '0;
      negativo       <= 1'b0;
      cero           <= 1'b0;
      acarreo        <= 1'b0;
      desbordamiento <= 1'b0;
      div_cero       <= 1'b0;
    end else begin
      done <= (state == S_FIN);
      if (state == S_FIN) begin
        out            <= resVal;
        negativo       <= flg.n;
        cero           <= flg.z;
        acarreo        <= flg.c;
        desbordamiento <= flg.v;
        div_cero       <= opDz;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed table-driven bench for seq_alu (WIDTH=8).
// Covers every opcode, flags, latency, busy-ignore, back-to-back and reset abort.
module tb_seq_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       ci;
  logic       busy;
  logic       done;
  logic [7:0] out;
  logic       negativo;
  logic       cero;
  logic       acarreo;
  logic       desbordamiento;
  logic       div_cero;

  int nCmp = 0;
  int nBad = 0;

  seq_alu #(.WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .op            (op),
    .a             (a),
    .b             (b),
    .ci            (ci),
    .busy          (busy),
    .done          (done),
    .out           (out),
    .negativo      (negativo),
    .cero          (cero),
    .acarreo       (acarreo),
    .desbordamiento(desbordamiento),
    .div_cero      (div_cero)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] expOut;
    logic [4:0] expF;
    int         expLat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h required %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [4:0] flags();
    return {negativo, cero, acarreo,
            desbordamiento, div_cero};
  endfunction

  task automatic runOp(input logic [2:0] o,
                       input logic [7:0] x,
                       input logic [7:0] y,
                       input logic c,
                       output int lat);
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    ci = c;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busyAfterAccept", busy, 1);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    if (lat > 0) chk("busyInDone", busy, 0);
  endtask

  function automatic vec_t mk(input string n,
                              input logic [2:0] o,
                              input logic [7:0] x,
                              input logic [7:0] y,
                              input logic c,
                              input logic [7:0] r,
                              input logic [4:0] f,
                              input int l);
    vec_t v;
    v.name = n;
    v.op = o;
    v.a = x;
    v.b = y;
    v.ci = c;
    v.expOut = r;
    v.expF = f;
    v.expLat = l;
    return v;
  endfunction

  initial begin
    int lat;
    int nDone;
    // flags vector is {N,Z,C,V,DZ}
    vecs.push_back(mk("add200_100", 3'd0, 200, 100, 0, 8'h2C, 5'b00100, 1));
    vecs.push_back(mk("add127_1", 3'd0, 127, 1, 0, 8'h80, 5'b10010, 1));
    vecs.push_back(mk("add255_0ci", 3'd0, 255, 0, 1, 8'h00, 5'b01100, 1));
    vecs.push_back(mk("sub5_7", 3'd1, 5, 7, 0, 8'hFE, 5'b10000, 1));
    vecs.push_back(mk("sub9_9", 3'd1, 9, 9, 0, 8'h00, 5'b01100, 1));
    vecs.push_back(mk("sub80_1", 3'd1, 8'h80, 1, 0, 8'h7F, 5'b00110, 1));
    vecs.push_back(mk("mul20_13", 3'd2, 20, 13, 0, 8'h04, 5'b00010, 9));
    vecs.push_back(mk("mul12_10", 3'd2, 12, 10, 0, 8'd120, 5'b00000, 9));
    vecs.push_back(mk("mulFF_FF", 3'd2, 255, 255, 0, 8'h01, 5'b00010, 9));
    vecs.push_back(mk("div100_7", 3'd3, 100, 7, 0, 8'd14, 5'b00000, 9));
    vecs.push_back(mk("mod100_7", 3'd4, 100, 7, 0, 8'd2, 5'b00000, 9));
    vecs.push_back(mk("div5_0", 3'd3, 5, 0, 0, 8'hFF, 5'b10001, 1));
    vecs.push_back(mk("mod5_0", 3'd4, 5, 0, 0, 8'h05, 5'b00001, 1));
    vecs.push_back(mk("divFF_1", 3'd3, 255, 1, 0, 8'hFF, 5'b10000, 9));
    vecs.push_back(mk("div7_9", 3'd3, 7, 9, 0, 8'h00, 5'b01000, 9));
    vecs.push_back(mk("mod7_9", 3'd4, 7, 9, 0, 8'h07, 5'b00000, 9));
    vecs.push_back(mk("andF0_3C", 3'd5, 8'hF0, 8'h3C, 0, 8'h30, 5'b00000, 1));
    vecs.push_back(mk("orF0_0F", 3'd6, 8'hF0, 8'h0F, 0, 8'hFF, 5'b10000, 1));
    vecs.push_back(mk("xorAA_AA", 3'd7, 8'hAA, 8'hAA, 0, 8'h00, 5'b01000, 1));

    rst = 1'b1;
    start = 1'b0;
    op = 3'd0;
    a = 8'd0;
    b = 8'd0;
    ci = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("resetState",
        {busy, done, out, flags()}, 15'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      runOp(vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].ci, lat);
      chk({vecs[i].name, "_lat"}, lat, vecs[i].expLat);
      chk({vecs[i].name, "_out"}, out, vecs[i].expOut);
      chk({vecs[i].name, "_flags"}, flags(), vecs[i].expF);
    end

    // start during MUL busy is ignored; result/flags held meanwhile
    @(negedge clk);
    start = 1'b1;
    op = 3'd2;
    a = 20;
    b = 13;
    @(posedge clk);
    #1;
    op = 3'd0;
    a = 1;
    b = 1;
    @(posedge clk);
    #1;
    chk("holdOutBusy", out, 8'h00);
    chk("holdZBusy", cero, 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = -1;
    for (int i = 3; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    chk("ignoreLat", lat, 9);
    chk("ignoreOut", out, 8'h04);
    @(posedge clk);
    #1;
    chk("ignoreNoQueue", {busy, done}, 2'b00);
    chk("ignoreOutHeld", out, 8'h04);

    // back-to-back with start held high
    @(negedge clk);
    start = 1'b1;
    op = 3'd0;
    a = 3;
    b = 4;
    lat = -1;
    for (int i = 0; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    chk("b2bFirstLat", lat, 1);
    chk("b2bFirstOut", out, 8'd7);
    a = 10;
    @(posedge clk);
    #1;
    chk("b2bReaccept", {busy, done}, 2'b10);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2bSecondDone", done, 1);
    chk("b2bSecondOut", out, 8'd14);
    @(posedge clk);
    #1;
    chk("b2bStop", busy, 0);

    // reset in the middle of a DIV
    @(negedge clk);
    start = 1'b1;
    op = 3'd3;
    a = 100;
    b = 7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rstAbortOut",
        {busy, done, out, flags()}, 15'd0);
    @(negedge clk);
    rst = 1'b0;
    nDone = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (done) nDone++;
    end
    chk("rstNoDone", nDone, 0);
    runOp(3'd0, 1, 1, 0, lat);
    chk("postRstLat", lat, 1);
    chk("postRstOut", out, 8'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nBad);
    $finish;
  end

endmodule
